alu_arbiter: RTL and testbench

Shares the single combinational ALU between N requesters, such as the control sequencer, an I/O unit and a debug port.
- Arbitration is round-robin.
- The granted requester's opcode and operands are latched, driven onto the ALU, and the result and flags are captured.
- Completion is returned with a one-cycle done pulse to that requester.
- The block sits between the requesters and the ALU, and is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between N requesters.
// Grants one requester per 3-cycle IDLE/ISSUE/DONE transaction and returns its captured result.
module alu_arbiter #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N*8-1:0]    opcode_i,
    input  logic [N*DW-1:0]   a_i,
    input  logic [N*DW-1:0]   b_i,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      done,
    output logic [DW-1:0]     result_o,
    output logic [4:0]        flags_o,
    output logic              err_o,
    output logic              busy,
    output logic [7:0]        alu_opcode,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    input  logic [DW-1:0]     alu_result,
    input  logic [4:0]        alu_flags
);

    localparam logic [7:0] OP_NOP = 8'hFF;
    localparam logic [7:0] OP_DIV = 8'h03;
    localparam logic [7:0] OP_MOD = 8'h04;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic [IDXW-1:0]   last_reg, last_next;
    logic              div0_reg, div0_next;
    logic [N-1:0]      gnt_reg, gnt_next;
    logic [N-1:0]      done_reg, done_next;
    logic [DW-1:0]     result_reg, result_next;
    logic [4:0]        flags_reg, flags_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;
    logic [7:0]        alu_opcode_reg, alu_opcode_next;
    logic [DW-1:0]     alu_a_reg, alu_a_next;
    logic [DW-1:0]     alu_b_reg, alu_b_next;

    logic [7:0]        op_arr [N];
    logic [DW-1:0]     a_arr  [N];
    logic [DW-1:0]     b_arr  [N];

    logic              pick_valid;
    logic [IDXW-1:0]   pick_idx;
    logic [IDXW-1:0]   pick_cand;
    logic [7:0]        sel_op;
    logic [DW-1:0]     sel_b;
    logic              sel_div0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign op_arr[gi] = opcode_i[8*gi +: 8];
            assign a_arr[gi]  = a_i[DW*gi +: DW];
            assign b_arr[gi]  = b_i[DW*gi +: DW];
        end
    endgenerate

    // Scan from furthest to nearest after last, so the nearest requester wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_cand  = '0;
        for (int i = N; i >= 1; i--) begin
            pick_cand = IDXW'((int'(last_reg) + i) % N);
            if (req[pick_cand]) begin
                pick_valid = 1'b1;
                pick_idx   = pick_cand;
            end
        end
    end

    assign sel_op   = op_arr[pick_idx];
    assign sel_b    = b_arr[pick_idx];
    assign sel_div0 = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            last_reg       <= IDXW'(N - 1);
            div0_reg       <= 1'b0;
            gnt_reg        <= '0;
            done_reg       <= '0;
            result_reg     <= '0;
            flags_reg      <= '0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            alu_opcode_reg <= OP_NOP;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            last_reg       <= last_next;
            div0_reg       <= div0_next;
            gnt_reg        <= gnt_next;
            done_reg       <= done_next;
            result_reg     <= result_next;
            flags_reg      <= flags_next;
            err_reg        <= err_next;
            busy_reg       <= busy_next;
            alu_opcode_reg <= alu_opcode_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (pick_valid) state_next = S_ISSUE;
            S_ISSUE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        idx_next        = idx_reg;
        last_next       = last_reg;
        div0_next       = div0_reg;
        gnt_next        = gnt_reg;
        done_next       = done_reg;
        result_next     = result_reg;
        flags_next      = flags_reg;
        err_next        = err_reg;
        busy_next       = busy_reg;
        alu_opcode_next = alu_opcode_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        case (state_reg)
            S_IDLE: begin
                alu_opcode_next = OP_NOP;
                if (pick_valid) begin
                    idx_next           = pick_idx;
                    div0_next          = sel_div0;
                    gnt_next           = '0;
                    gnt_next[pick_idx] = 1'b1;
                    busy_next          = 1'b1;
                    // A divide by zero never reaches the ALU; it sees a NOP instead.
                    alu_opcode_next    = sel_div0 ? OP_NOP : sel_op;
                    alu_a_next         = a_arr[pick_idx];
                    alu_b_next         = sel_b;
                end
            end
            S_ISSUE: begin
                done_next   = gnt_reg;
                result_next = div0_reg ? '1 : alu_result;
                flags_next  = div0_reg ? 5'b0 : alu_flags;
                err_next    = div0_reg;
            end
            S_DONE: begin
                last_next       = idx_reg;
                gnt_next        = '0;
                done_next       = '0;
                busy_next       = 1'b0;
                err_next        = 1'b0;
                alu_opcode_next = OP_NOP;
            end
            default: ;
        endcase
    end

    assign gnt        = gnt_reg;
    assign done       = done_reg;
    assign result_o   = result_reg;
    assign flags_o    = flags_reg;
    assign err_o      = err_reg;
    assign busy       = busy_reg;
    assign alu_opcode = alu_opcode_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stand-in ALU, directed scenarios, then random requests
// checked against a round-robin transaction model.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*8-1:0]    opcode_i = '0;
    logic [N*DW-1:0]   a_i = '0;
    logic [N*DW-1:0]   b_i = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [DW-1:0]     result_o;
    logic [4:0]        flags_o;
    logic              err_o;
    logic              busy;
    logic [7:0]        alu_opcode;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [DW-1:0]     alu_result;
    logic [4:0]        alu_flags;

    int n_cmp = 0;
    int n_err = 0;
    int last_m = N - 1;
    int wait_cnt [N];
    logic [7:0] r_op [N];
    logic [7:0] r_a  [N];
    logic [7:0] r_b  [N];

    alu_arbiter #(.N(N), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .opcode_i(opcode_i), .a_i(a_i), .b_i(b_i),
        .gnt(gnt), .done(done), .result_o(result_o), .flags_o(flags_o), .err_o(err_o),
        .busy(busy), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: returns {overflow, parity, sign, carry, zero, result}.
    function automatic logic [12:0] alu_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] wide;
        logic [7:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; wide = '0;
        case (op)
            8'h00: begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8];
                         v = (a[7] == b[7]) && (r[7] != a[7]); end
            8'h01: begin wide = {1'b0, a} - {1'b0, b}; r = wide[7:0]; c = wide[8];
                         v = (a[7] != b[7]) && (r[7] != a[7]); end
            8'h02: r = a & b;
            8'h03: r = (b == 8'h00) ? 8'h00 : a / b;
            8'h04: r = (b == 8'h00) ? 8'h00 : a % b;
            8'hFF: begin r = 8'hA5; c = 1'b1; v = 1'b1; end
            default: r = a ^ b ^ op;
        endcase
        return {v, ^r, r[7], c, (r == 8'h00), r};
    endfunction

    always_comb begin
        {alu_flags, alu_result} = alu_model(alu_opcode, alu_a, alu_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int rr_pick();
        int k;
        for (int i = 1; i <= N; i++) begin
            k = (last_m + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic raise(input int k, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode_i[8*k +: 8] = op;
        a_i[8*k +: 8] = a;
        b_i[8*k +: 8] = b;
        r_op[k] = op; r_a[k] = a; r_b[k] = b;
        req[k] = 1'b1;
        wait_cnt[k] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_m = N - 1;
    endtask

    // One full transaction starting in IDLE; returns the granted index.
    task automatic serve(output int idx);
        logic [7:0] eop, ea, eb, eres;
        logic [12:0] ar;
        logic dz;
        logic [N-1:0] oh;
        idx = rr_pick();
        if (idx < 0) return;
        eop = r_op[idx]; ea = r_a[idx]; eb = r_b[idx];
        dz = ((eop == 8'h03) || (eop == 8'h04)) && (eb == 8'h00);
        ar = alu_model(eop, ea, eb);
        eres = dz ? 8'hFF : ar[7:0];
        oh = '0; oh[idx] = 1'b1;
        @(posedge clk); #1;
        check("issue_gnt", gnt, oh);
        check("issue_busy", busy, 1);
        check("issue_done", done, 0);
        check("issue_alu_op", alu_opcode, dz ? 8'hFF : eop);
        check("issue_alu_a", alu_a, ea);
        check("issue_alu_b", alu_b, eb);
        // Operands change after grant; the latched copies must be used.
        opcode_i[8*idx +: 8] = 8'($urandom);
        a_i[8*idx +: 8] = 8'($urandom);
        b_i[8*idx +: 8] = 8'($urandom);
        @(posedge clk); #1;
        check("done_pulse", done, oh);
        check("done_gnt", gnt, oh);
        check("done_busy", busy, 1);
        check("done_alu_op", alu_opcode, dz ? 8'hFF : eop);
        check("done_result", result_o, eres);
        check("done_flags", flags_o, dz ? 5'b0 : ar[12:8]);
        check("done_err", err_o, dz);
        req[idx] = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k != idx && req[k]) begin
                wait_cnt[k]++;
                check("rr_bound", (wait_cnt[k] <= N - 1), 1);
            end
        end
        @(posedge clk); #1;
        check("idle_gnt", gnt, 0);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_alu_op", alu_opcode, 8'hFF);
        check("idle_err", err_o, 0);
        check("idle_result_held", result_o, eres);
        last_m = idx;
        $display("txn req%0d op=%02h a=%02h b=%02h -> result=%02h err=%0d", idx, eop, ea, eb, eres, dz);
    endtask

    initial begin
        int idx;
        logic [7:0] op, bv;
        for (int k = 0; k < N; k++) begin
            wait_cnt[k] = 0; r_op[k] = '0; r_a[k] = '0; r_b[k] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result_o, 0);
        check("rst_flags", flags_o, 0);
        check("rst_err", err_o, 0);
        check("rst_alu_op", alu_opcode, 8'hFF);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        reset = 1'b1;

        // ADD 5+3 on requester 0
        raise(0, 8'h00, 8'h05, 8'h03);
        serve(idx);
        check("t1_idx", idx, 0);
        check("t1_result", result_o, 8'h08);
        check("t1_flags", flags_o, 5'b01000);

        // ADD FF+01 on requester 1: wraps to zero with carry
        raise(1, 8'h00, 8'hFF, 8'h01);
        serve(idx);
        check("t2_idx", idx, 1);
        check("t2_result", result_o, 8'h00);
        check("t2_flags", flags_o, 5'b00011);

        // DIV by zero on requester 3
        raise(3, 8'h03, 8'h10, 8'h00);
        serve(idx);
        check("t5_idx", idx, 3);
        check("t5_result", result_o, 8'hFF);
        check("t5_flags", flags_o, 0);

        // All four requesting after reset
        do_reset();
        for (int k = 0; k < N; k++) raise(k, 8'($urandom_range(4, 0)), 8'($urandom), 8'($urandom));
        for (int i = 0; i < N; i++) begin
            serve(idx);
            check("t3_order", idx, i);
        end

        // Requesters 0 and 2 re-request immediately after each completion
        do_reset();
        raise(0, 8'h01, 8'h20, 8'h10);
        raise(2, 8'h02, 8'hF0, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            serve(idx);
            check("t4_order", idx, (i % 2) * 2);
            raise(idx, 8'($urandom_range(2, 0)), 8'($urandom), 8'($urandom));
        end
        req = '0;
        @(posedge clk); #1;

        // Reset during ISSUE for requester 2
        raise(2, 8'h00, 8'h11, 8'h22);
        @(posedge clk); #1;
        check("t6_issue_gnt", gnt, 4'b0100);
        reset = 1'b0;
        @(posedge clk); #1;
        last_m = N - 1;
        check("t6_gnt", gnt, 0);
        check("t6_done", done, 0);
        check("t6_busy", busy, 0);
        check("t6_result", result_o, 0);
        check("t6_alu_op", alu_opcode, 8'hFF);
        raise(0, 8'h00, 8'h01, 8'h01);
        raise(2, 8'h00, 8'h11, 8'h22);
        reset = 1'b1;
        serve(idx);
        check("t6_first", idx, 0);
        serve(idx);
        check("t6_second", idx, 2);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(1, 0) == 1) begin
                    case ($urandom_range(6, 0))
                        0: op = 8'h00;
                        1: op = 8'h01;
                        2: op = 8'h02;
                        3: op = 8'h03;
                        4: op = 8'h04;
                        5: op = 8'h13;
                        default: op = 8'($urandom);
                    endcase
                    bv = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom);
                    raise(k, op, 8'($urandom), bv);
                end
            end
            if (req != '0) serve(idx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
